// File: rtl/apple1_uart_rx_fifo.sv
// Apple 1 console UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding
// a show-ahead byte FIFO with registered CTS flow control.
`timescale 1ns/1ps
module apple1_uart_rx_fifo #(
   parameter int CLK_FREQ      = 25000000,
   parameter int BAUD          = 115200,
   parameter int FIFO_DEPTH    = 8,
   parameter int CTS_THRESHOLD = 6
) (
   input  logic                          clk25,
   input  logic                          rst,
   input  logic                          uart_rx,
   output logic                          uart_cts,
   input  logic                          rd_en,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overrun,
   output logic                          frame_err,
   output logic                          parity_err
);

   localparam int DIV  = CLK_FREQ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CNTW = $clog2(DIV + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;

   localparam logic [CNTW-1:0] DIV_C  = CNTW'(DIV);
   localparam logic [CNTW-1:0] HALF_C = CNTW'(HALF);
   localparam logic [CW-1:0]   FULL_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]   CTS_C  = CW'(CTS_THRESHOLD);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
   } state_t;
`endif

   logic            rx_meta, rx_s;
   state_t          state;
   logic [CNTW-1:0] bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            tick, stop_tick, par_bad;
   logic            push_req, push, pop, full;

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   // Sample points fire when the down-counter reaches 1, so a reload of
   // DIV spaces consecutive samples exactly one bit period apart.
   assign tick      = (bit_cnt == CNTW'(1));
   assign stop_tick = (state == S_STOP) && tick;

`ifdef UART_RX_PARITY_EN
   logic par;
   assign par_bad = ^{shreg, par};
`else
   assign par_bad = 1'b0;
`endif

   assign full     = (count == FULL_C);
   assign rd_valid = (count != '0);
   assign pop      = rd_en && rd_valid;
   assign push_req = stop_tick && rx_s && !par_bad;
   assign push     = push_req && (!full || pop);
   assign rd_data  = mem[rd_ptr];

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  bit_cnt <= HALF_C;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (tick) begin
                  bit_cnt <= DIV_C;
                  bit_idx <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  bit_cnt <= bit_cnt - CNTW'(1);
               end
            end
            S_DATA: begin
               if (tick) begin
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= DIV_C;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  bit_cnt <= bit_cnt - CNTW'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (tick) begin
                  par     <= rx_s;
                  bit_cnt <= DIV_C;
                  state   <= S_STOP;
               end else begin
                  bit_cnt <= bit_cnt - CNTW'(1);
               end
            end
`endif
            S_STOP: begin
               if (tick) begin
                  state <= rx_s ? S_IDLE : S_BREAK;
               end else begin
                  bit_cnt <= bit_cnt - CNTW'(1);
               end
            end
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) begin
         uart_cts  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         uart_cts  <= (count >= CTS_C);
         overrun   <= push_req && full && !pop;
         frame_err <= stop_tick && !rx_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   // A bad stop bit outranks a parity mismatch.
   always_ff @(posedge clk25 or posedge rst) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= stop_tick && rx_s && par_bad;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
